// File: rtl/cla32_seq_mul_ctrl_pkg.sv
// Shared types and constants for the sequential shift-add multiplier.
package cla32_seq_mul_ctrl_pkg;

    localparam int MUL_W  = 32;
    localparam int PROD_W = 64;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/CLA_Array_32.sv
// 32-bit carry-lookahead adder: 4-bit lookahead groups chained on group carries.
module CLA_Array_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] sum,
    output logic        cout
);

    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;

    assign g = a & b;
    assign p = a ^ b;

    // Per-group lookahead carries, then the group carry feeds the next group.
    always_comb begin
        logic carry;
        logic gg;
        logic gp;
        c     = '0;
        carry = cin;
        for (int k = 0; k < 8; k++) begin
            c[4*k]   = carry;
            c[4*k+1] = g[4*k] | (p[4*k] & carry);
            c[4*k+2] = g[4*k+1] | (p[4*k+1] & g[4*k]) | (p[4*k+1] & p[4*k] & carry);
            c[4*k+3] = g[4*k+2] | (p[4*k+2] & g[4*k+1]) | (p[4*k+2] & p[4*k+1] & g[4*k])
                     | (p[4*k+2] & p[4*k+1] & p[4*k] & carry);
            gg = g[4*k+3] | (p[4*k+3] & g[4*k+2]) | (p[4*k+3] & p[4*k+2] & g[4*k+1])
               | (p[4*k+3] & p[4*k+2] & p[4*k+1] & g[4*k]);
            gp = &p[4*k +: 4];
            carry = gg | (gp & carry);
        end
        c[32] = carry;
    end

    assign sum  = p ^ c[31:0];
    assign cout = c[32];

endmodule

// File: rtl/cla32_seq_mul_ctrl.sv
// Sequential 32x32 -> 64 unsigned shift-add multiplier around one shared CLA.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for operands, in_ready high
// RUN     | one partial-product accumulate + right shift per clock, 32 steps
// DONE    | product presented with out_valid; may reload directly into RUN
module cla32_seq_mul_ctrl
    import cla32_seq_mul_ctrl_pkg::*;
#(
    parameter int N_ITER = 32,
    parameter int CNT_W  = 6
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [MUL_W-1:0]    a,
    input  logic [MUL_W-1:0]    b,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [PROD_W-1:0]   product,
    output logic                busy
);

    state_t             state_q;
    state_t             state_d;
    logic [CNT_W-1:0]   counter;
    logic [MUL_W-1:0]   acc_hi;
    logic [MUL_W-1:0]   acc_lo;
    logic [MUL_W-1:0]   mcand;
    logic [MUL_W-1:0]   addend;
    logic [MUL_W-1:0]   sum;
    logic               cout;
    logic               accept;
    logic               last_iter;

    assign in_ready  = (state_q == ST_IDLE) | ((state_q == ST_DONE) & out_ready);
    assign accept    = in_valid & in_ready;
    assign last_iter = (counter == CNT_W'(N_ITER - 1));
    assign addend    = acc_lo[0] ? mcand : '0;

    CLA_Array_32 u_cla (
        .a    (acc_hi),
        .b    (addend),
        .cin  (1'b0),
        .sum  (sum),
        .cout (cout)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= ST_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; accept in DONE implies out_ready, so it skips IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN:  if (last_iter) state_d = ST_DONE;
            ST_DONE: begin
                if (accept)         state_d = ST_RUN;
                else if (out_ready) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Operand load on accept, accumulate-and-shift each RUN cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            mcand   <= '0;
        end else if (accept) begin
            counter <= '0;
            acc_hi  <= '0;
            acc_lo  <= b;
            mcand   <= a;
        end else if (state_q == ST_RUN) begin
            counter <= counter + CNT_W'(1);
            {acc_hi, acc_lo} <= {cout, sum, acc_lo[MUL_W-1:1]};
        end
    end

    assign out_valid = (state_q == ST_DONE);
    assign busy      = (state_q != ST_IDLE);
    assign product   = {acc_hi, acc_lo};

endmodule
